// File: rtl/uart_wb_master_if.sv
// Wishbone initiator bundle between uart_wb_master and a UART register block.
// The bus signals keep their Wishbone names so that the two sides map one to one.
interface uart_wb_master_if;
  logic        CYC_O;
  logic        STB_O;
  logic        WR_O;
  logic [2:0]  ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        ACK_I;

  modport master (
    output CYC_O, STB_O, WR_O, ADR_O, DAT_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  CYC_O, STB_O, WR_O, ADR_O, DAT_O,
    output DAT_I, ACK_I
  );
endinterface

// File: rtl/uart_wb_master.sv
// Programs a Wishbone UART (divider, txctrl, rxctrl), then moves bytes between stream ports and it.
// Optional ACK timeout with sticky bus_error: define UART_WB_MASTER_TIMEOUT_EN.
module uart_wb_master #(
  parameter int unsigned CLOCK_FREQ_HZ = 10000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned NSTOP         = 0,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  uart_wb_master_if.master        wb,
  input  logic [7:0]              tx_byte,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [7:0]              rx_byte,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    init_done
`ifdef UART_WB_MASTER_TIMEOUT_EN
  ,
  output logic                    bus_error
`endif
);

  localparam logic [15:0] DivVal    = 16'(CLOCK_FREQ_HZ / BAUD_RATE - 1);
  localparam logic        NstopBit  = (NSTOP != 0);
  localparam logic [31:0] TxCtrlVal = {13'b0, 3'b000, 14'b0, NstopBit, 1'b1};
  localparam logic [31:0] RxCtrlVal = 32'h0000_0001;

  localparam logic [2:0] AdrTxData = 3'd0;
  localparam logic [2:0] AdrRxData = 3'd1;
  localparam logic [2:0] AdrTxCtrl = 3'd2;
  localparam logic [2:0] AdrRxCtrl = 3'd3;
  localparam logic [2:0] AdrDiv    = 3'd6;

  typedef enum logic [2:0] {
    StInitDiv, StInitTx, StInitRx, StIdle, StTxCheck, StTxWrite, StRxRead
  } state_e;

  state_e      r_state, w_state_next;
  logic        r_cyc, w_cyc_next;
  logic        r_we, w_we_next;
  logic [2:0]  r_adr, w_adr_next;
  logic [31:0] r_dat, w_dat_next;
  logic        r_tx_held, w_tx_held_next;
  logic [7:0]  r_tx_data, w_tx_data_next;
  logic        r_rx_valid, w_rx_valid_next;
  logic [7:0]  r_rx_byte, w_rx_byte_next;
  logic        r_init_done, w_init_done_next;
  logic        r_rr_rx, w_rr_rx_next;

  logic        w_ack, w_timeout, w_done;
  logic        w_tx_req, w_rx_req, w_grant_tx, w_grant_rx;
  logic        w_tx_ready, w_tx_accept;
  logic        w_bus_op, w_bus_we;
  logic [2:0]  w_bus_adr;
  logic [31:0] w_bus_dat;

  // An ACK outside an open cycle is ignored.
  assign w_ack  = r_cyc && wb.ACK_I;
  assign w_done = w_ack || w_timeout;

  assign w_tx_ready  = (r_state == StIdle) && !r_tx_held;
  assign w_tx_accept = tx_valid && w_tx_ready;

  // A held byte keeps requesting until the UART FIFO has room for it.
  assign w_tx_req   = r_tx_held || tx_valid;
  assign w_rx_req   = !r_rx_valid;
  assign w_grant_tx = (r_state == StIdle) && w_tx_req && (!w_rx_req || !r_rr_rx);
  assign w_grant_rx = (r_state == StIdle) && w_rx_req && !w_grant_tx;

`ifdef UART_WB_MASTER_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_bus_error;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_to_cnt    <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_to_cnt <= r_cyc ? r_to_cnt + 32'd1 : 32'd0;
      if (w_timeout) begin
        r_bus_error <= 1'b1;
      end
    end
  end

  assign w_timeout = r_cyc && !wb.ACK_I && (r_to_cnt == 32'(ACK_TIMEOUT - 1));
  assign bus_error = r_bus_error;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state     <= StInitDiv;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_tx_held   <= 1'b0;
      r_tx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_byte   <= '0;
      r_init_done <= 1'b0;
      r_rr_rx     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cyc       <= w_cyc_next;
      r_we        <= w_we_next;
      r_adr       <= w_adr_next;
      r_dat       <= w_dat_next;
      r_tx_held   <= w_tx_held_next;
      r_tx_data   <= w_tx_data_next;
      r_rx_valid  <= w_rx_valid_next;
      r_rx_byte   <= w_rx_byte_next;
      r_init_done <= w_init_done_next;
      r_rr_rx     <= w_rr_rx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StInitDiv: if (w_ack) w_state_next = StInitTx;
      StInitTx: begin
        if (w_ack) begin
          w_state_next = StInitRx;
        end else if (w_timeout) begin
          w_state_next = StInitDiv;
        end
      end
      StInitRx: begin
        if (w_ack) begin
          w_state_next = StIdle;
        end else if (w_timeout) begin
          w_state_next = StInitDiv;
        end
      end
      StIdle: begin
        if (w_grant_tx) begin
          w_state_next = StTxCheck;
        end else if (w_grant_rx) begin
          w_state_next = StRxRead;
        end
      end
      StTxCheck: begin
        if (w_ack) begin
          w_state_next = wb.DAT_I[31] ? StIdle : StTxWrite;
        end else if (w_timeout) begin
          w_state_next = StIdle;
        end
      end
      StTxWrite, StRxRead: if (w_done) w_state_next = StIdle;
      default: w_state_next = StInitDiv;
    endcase
  end

  always_comb begin
    w_bus_op  = 1'b1;
    w_bus_we  = 1'b1;
    w_bus_adr = AdrTxData;
    w_bus_dat = '0;
    case (r_state)
      StInitDiv: begin
        w_bus_adr = AdrDiv;
        w_bus_dat = {16'b0, DivVal};
      end
      StInitTx: begin
        w_bus_adr = AdrTxCtrl;
        w_bus_dat = TxCtrlVal;
      end
      StInitRx: begin
        w_bus_adr = AdrRxCtrl;
        w_bus_dat = RxCtrlVal;
      end
      StTxCheck: w_bus_we = 1'b0;
      StTxWrite: w_bus_dat = {24'b0, r_tx_data};
      StRxRead: begin
        w_bus_we  = 1'b0;
        w_bus_adr = AdrRxData;
      end
      default: w_bus_op = 1'b0;
    endcase

    // A state change only happens as the cycle closes, so a new cycle starts one idle cycle later.
    w_cyc_next = r_cyc;
    w_we_next  = r_we;
    w_adr_next = r_adr;
    w_dat_next = r_dat;
    if (r_cyc) begin
      if (w_done) w_cyc_next = 1'b0;
    end else if (w_bus_op) begin
      w_cyc_next = 1'b1;
      w_we_next  = w_bus_we;
      w_adr_next = w_bus_adr;
      w_dat_next = w_bus_dat;
    end

    w_tx_held_next = r_tx_held;
    w_tx_data_next = r_tx_data;
    if (w_tx_accept) begin
      w_tx_held_next = 1'b1;
      w_tx_data_next = tx_byte;
    end else if ((r_state == StTxWrite) && w_ack) begin
      w_tx_held_next = 1'b0;
    end

    w_rx_valid_next = r_rx_valid;
    w_rx_byte_next  = r_rx_byte;
    if ((r_state == StRxRead) && w_ack && !wb.DAT_I[31]) begin
      w_rx_valid_next = 1'b1;
      w_rx_byte_next  = wb.DAT_I[7:0];
    end else if (r_rx_valid && rx_ready) begin
      w_rx_valid_next = 1'b0;
    end

    w_init_done_next = r_init_done || ((r_state == StInitRx) && w_ack);
    w_rr_rx_next     = (w_grant_tx || w_grant_rx) ? !r_rr_rx : r_rr_rx;
  end

  assign wb.CYC_O  = r_cyc;
  assign wb.STB_O  = r_cyc;
  assign wb.WR_O   = r_we;
  assign wb.ADR_O  = r_adr;
  assign wb.DAT_O  = r_dat;
  assign tx_ready  = w_tx_ready;
  assign rx_valid  = r_rx_valid;
  assign rx_byte   = r_rx_byte;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed/randomized bench for uart_wb_master against a small UART register responder model.
module tb_uart_wb_master;
  localparam int unsigned ClkHz = 10000000;
  localparam int unsigned Baud  = 115200;
  localparam int unsigned Nstop = 0;

  typedef struct packed {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat;
  } txn_t;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic [7:0] tx_byte = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       init_done;
  logic       stuck = 1'b0;
`ifdef UART_WB_MASTER_TIMEOUT_EN
  logic       bus_error;
`endif

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  txn_t log_q[$];
  logic full_q[$];
  logic [7:0] rx_q[$];

  always #5 CLK_I = ~CLK_I;

  uart_wb_master_if bus();

  uart_wb_master #(
    .CLOCK_FREQ_HZ(ClkHz),
    .BAUD_RATE    (Baud),
    .NSTOP        (Nstop),
    .ACK_TIMEOUT  (255)
  ) dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .wb       (bus),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .init_done(init_done)
`ifdef UART_WB_MASTER_TIMEOUT_EN
    ,
    .bus_error(bus_error)
`endif
  );

  // Responder: ACK two cycles into each cycle; also logs completed transfers and protocol slips.
  int   wcnt = 0;
  logic prev_cyc = 1'b0;
  logic prev_done = 1'b0;
  txn_t prev_txn = '0;

  always @(posedge CLK_I) begin
    if (RST_I) begin
      bus.ACK_I <= 1'b0;
      bus.DAT_I <= '0;
      wcnt      <= 0;
      prev_cyc  <= 1'b0;
      prev_done <= 1'b0;
    end else begin
      viol <= viol + int'(bus.STB_O !== bus.CYC_O) + int'(prev_done && bus.CYC_O)
            + int'(prev_cyc && bus.CYC_O && !prev_done &&
                   (prev_txn != {bus.WR_O, bus.ADR_O, bus.DAT_O}));
      prev_cyc  <= bus.CYC_O;
      prev_done <= bus.CYC_O && bus.ACK_I;
      prev_txn  <= {bus.WR_O, bus.ADR_O, bus.DAT_O};
      if (bus.CYC_O && bus.ACK_I) log_q.push_back({bus.WR_O, bus.ADR_O, bus.DAT_O});
      bus.ACK_I <= 1'b0;
      if (bus.CYC_O && !bus.ACK_I && !stuck) begin
        if (wcnt == 1) begin
          wcnt      <= 0;
          bus.ACK_I <= 1'b1;
          if (!bus.WR_O && bus.ADR_O == 3'd0) begin
            if (full_q.size() > 0) bus.DAT_I <= {full_q.pop_front(), 31'h0};
            else                   bus.DAT_I <= 32'h0;
          end else if (!bus.WR_O && bus.ADR_O == 3'd1) begin
            if (rx_q.size() > 0) bus.DAT_I <= {1'b0, 23'($urandom), rx_q.pop_front()};
            else                 bus.DAT_I <= 32'h8000_0000;
          end else begin
            bus.DAT_I <= $urandom;
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end else if (!bus.CYC_O) begin
        wcnt <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 300) begin
      @(negedge CLK_I);
      n++;
    end
    chk("init_done", 64'(init_done), 64'd1);
  endtask

  task automatic do_tx(input logic [7:0] b, input int k);
    int n, rd, wr, last_rd, wr_idx;
    logic [31:0] wr_dat;
    for (int i = 0; i < k; i++) full_q.push_back(1'b1);
    @(negedge CLK_I);
    log_q.delete();
    tx_byte  = b;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge CLK_I);
      n++;
    end
    chk("tx_accept", 64'(n < 500), 64'd1);
    @(posedge CLK_I);
    #1 tx_valid = 1'b0;
    @(negedge CLK_I);
    n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge CLK_I);
      n++;
    end
    chk("tx_ready_back", 64'(tx_ready), 64'd1);
    rd = 0; wr = 0; last_rd = -1; wr_idx = -1; wr_dat = '0;
    foreach (log_q[i]) begin
      if (log_q[i].adr == 3'd0) begin
        if (log_q[i].we) begin
          wr++;
          wr_idx = i;
          wr_dat = log_q[i].dat;
        end else begin
          rd++;
          last_rd = i;
        end
      end
    end
    chk("tx_check_reads", 64'(rd), 64'(k + 1));
    chk("tx_writes", 64'(wr), 64'd1);
    chk("tx_wdata", 64'(wr_dat), {56'b0, b});
    chk("tx_write_after_reads", 64'(wr_idx > last_rd), 64'd1);
    chk("tx_full_consumed", 64'(full_q.size()), 64'd0);
  endtask

  task automatic do_rx(input logic [7:0] b);
    int n;
    int found;
    @(negedge CLK_I);
    rx_ready = 1'b0;
    rx_q.push_back(b);
    n = 0;
    while (!rx_valid && n < 500) begin
      @(negedge CLK_I);
      n++;
    end
    chk("rx_valid_set", 64'(rx_valid), 64'd1);
    chk("rx_byte", 64'(rx_byte), 64'(b));
    log_q.delete();
    repeat (20) @(negedge CLK_I);
    n = 0;
    foreach (log_q[i]) if (log_q[i].adr == 3'd1) n++;
    chk("rx_no_read_while_valid", 64'(n), 64'd0);
    chk("rx_valid_held", 64'(rx_valid), 64'd1);
    chk("rx_byte_held", 64'(rx_byte), 64'(b));
    rx_ready = 1'b1;
    @(negedge CLK_I);
    rx_ready = 1'b0;
    chk("rx_valid_clear", 64'(rx_valid), 64'd0);
    log_q.delete();
    found = 0;
    n = 0;
    while (found == 0 && n < 200) begin
      @(negedge CLK_I);
      n++;
      foreach (log_q[i]) if (log_q[i].adr == 3'd1 && !log_q[i].we) found = 1;
    end
    chk("rx_poll_resumes", 64'(found), 64'd1);
  endtask

  task automatic do_alternate(input logic [7:0] b);
    txn_t snap[$];
    int   svc[$];
    int   i, first_t, bad, n_t, bad_w, n;
    @(negedge CLK_I);
    rx_ready = 1'b1;
    tx_byte  = b;
    tx_valid = 1'b1;
    log_q.delete();
    repeat (400) @(negedge CLK_I);
    snap = log_q;
    tx_valid = 1'b0;
    n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge CLK_I);
      n++;
    end
    chk("alt_drain", 64'(tx_ready), 64'd1);
    // 0 = TX service (read+write addr0), 1 = RX read, 2 = anything else
    i = 0; bad_w = 0;
    while (i < snap.size()) begin
      if (snap[i].adr == 3'd1 && !snap[i].we) begin
        svc.push_back(1);
        i++;
      end else if (snap[i].adr == 3'd0 && !snap[i].we && i + 1 < snap.size() &&
                   snap[i+1].adr == 3'd0 && snap[i+1].we) begin
        svc.push_back(0);
        if (snap[i+1].dat != {24'b0, b}) bad_w++;
        i += 2;
      end else begin
        svc.push_back(2);
        i++;
      end
    end
    first_t = -1;
    foreach (svc[j]) if (first_t < 0 && svc[j] == 0) first_t = j;
    bad = 0; n_t = 0;
    if (first_t >= 0) begin
      n_t = 1;
      for (int m = first_t + 1; m < svc.size() - 1; m++) begin
        if (svc[m] == svc[m-1] || svc[m] == 2) bad++;
        if (svc[m] == 0) n_t++;
      end
    end
    chk("alt_pattern", 64'(bad), 64'd0);
    chk("alt_tx_count", 64'(n_t >= 10), 64'd1);
    chk("alt_wdata", 64'(bad_w), 64'd0);
    rx_ready = 1'b0;
  endtask

  initial begin
    txn_t exp_init[3];
    int   n;
    exp_init[0] = {1'b1, 3'd6, 32'(ClkHz / Baud - 1)};
    exp_init[1] = {1'b1, 3'd2, 32'((Nstop != 0 ? 2 : 0) + 1)};
    exp_init[2] = {1'b1, 3'd3, 32'h0000_0001};

    repeat (3) @(posedge CLK_I);
    #1;
    chk("rst_cyc", 64'(bus.CYC_O), 64'd0);
    chk("rst_stb", 64'(bus.STB_O), 64'd0);
    chk("rst_wr", 64'(bus.WR_O), 64'd0);
    chk("rst_adr", 64'(bus.ADR_O), 64'd0);
    chk("rst_dat", 64'(bus.DAT_O), 64'd0);
    chk("rst_tx_ready", 64'(tx_ready), 64'd0);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_rx_byte", 64'(rx_byte), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
`ifdef UART_WB_MASTER_TIMEOUT_EN
    chk("rst_bus_error", 64'(bus_error), 64'd0);
`endif

    @(negedge CLK_I);
    RST_I = 1'b0;
    log_q.delete();
    wait_init();
    chk("init_txn_count", 64'(log_q.size() >= 3), 64'd1);
    for (int i = 0; i < 3; i++) begin
      txn_t got;
      got = (i < log_q.size()) ? log_q[i] : '0;
      chk($sformatf("init_txn%0d", i), 64'(got), 64'(exp_init[i]));
    end

    do_tx(8'h41, 0);
    do_tx(8'($urandom), 3);
    do_tx(8'($urandom), int'($urandom_range(0, 3)));
    do_tx(8'($urandom), int'($urandom_range(0, 3)));

    do_rx(8'h5A);
    do_rx(8'($urandom));

    do_alternate(8'($urandom));

    // Reset in the middle of a transfer
    n = 0;
    while (!bus.CYC_O && n < 100) begin
      @(negedge CLK_I);
      n++;
    end
    RST_I = 1'b1;
    @(posedge CLK_I);
    #1;
    chk("midrst_cyc", 64'(bus.CYC_O), 64'd0);
    chk("midrst_init_done", 64'(init_done), 64'd0);
    chk("midrst_tx_ready", 64'(tx_ready), 64'd0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    log_q.delete();
    wait_init();
    chk("midrst_restart", 64'((log_q.size() > 0) ? log_q[0] : '0), 64'(exp_init[0]));

`ifdef UART_WB_MASTER_TIMEOUT_EN
    @(negedge CLK_I);
    stuck = 1'b1;
    n = 0;
    while (bus.CYC_O && n < 1000) begin
      @(negedge CLK_I);
      n++;
    end
    n = 0;
    while (!bus.CYC_O && n < 100) begin
      @(negedge CLK_I);
      n++;
    end
    n = 0;
    while (bus.CYC_O && n < 1000) begin
      @(negedge CLK_I);
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'd255);
    chk("timeout_bus_error", 64'(bus_error), 64'd1);
    stuck = 1'b0;
    RST_I = 1'b1;
    @(negedge CLK_I);
    RST_I = 1'b0;
    chk("timeout_cleared", 64'(bus_error), 64'd0);
    wait_init();
`endif

    chk("bus_protocol", 64'(viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_wb_master.md
UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQ_HZ, default 10000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, meaning target baud rate.
REQ-003 The block SHALL have parameter NSTOP, default 0, meaning the stop-bit select written to txctrl bit 1.
REQ-004 The block SHALL have parameter ACK_TIMEOUT, default 255, meaning the maximum number of cycles spent waiting for ACK_I.
REQ-005 The block SHALL have port CLK_I input 1, the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port RST_I input 1, reset, synchronous and active-high.
REQ-007 The block SHALL have the following Wishbone initiator ports:
  - CYC_O output 1 and STB_O output 1: cycle and strobe.
  - WR_O output 1: 1 = write.
  - ADR_O output 3: UART register index.
  - DAT_O output 32: write data.
  - DAT_I input 32: read data.
  - ACK_I input 1: responder acknowledge.
REQ-008 The block SHALL have the following transmit-side ports:
  - tx_byte input 8 and tx_valid input 1: byte to send.
  - tx_ready output 1: byte accepted when tx_valid and tx_ready are both 1.
REQ-009 The block SHALL have the following receive-side ports:
  - rx_byte output 8 and rx_valid output 1: received byte.
  - rx_ready input 1: consumer accepts the byte.
REQ-010 The block SHALL have the following status ports:
  - init_done output 1: initialization complete.
  - bus_error output 1: sticky timeout flag; it exists only under the macro defined in REQ-028.

Function
REQ-011 The block SHALL use the register map: 0 txdata (bit31 = full), 1 rxdata (bit31 = empty; a read pops), 2 txctrl, 3 rxctrl, 6 div.
REQ-012 Each bus transaction SHALL follow these rules:
  - CYC_O, STB_O, WR_O, ADR_O and DAT_O are registered and held stable from assertion until the cycle ACK_I is sampled 1.
  - CYC_O and STB_O drop in the following cycle.
  - At least one idle cycle (CYC_O = STB_O = 0) separates consecutive transactions.
REQ-013 Read data SHALL be captured from DAT_I in the cycle ACK_I is sampled 1.
REQ-014 After reset, the FSM SHALL perform, in order:
  - INIT_DIV: write addr 6, data = CLOCK_FREQ_HZ/BAUD_RATE-1 (integer division).
  - INIT_TX: write addr 2, data = {13'b0, 3'b000, 14'b0, NSTOP, 1'b1}.
  - INIT_RX: write addr 3, data = 32'h00000001.
  - Then enter IDLE and set init_done = 1.
REQ-015 IDLE SHALL serve two request types:
  - TX request: tx_valid = 1 and no byte held in the TX holding register.
  - RX request: rx_valid = 0.
  - When both are eligible, a round-robin pointer picks one and the pointer toggles after each served request; the pointer resets to TX.
REQ-016 tx_ready SHALL be 1 only in IDLE with the TX holding register empty; acceptance latches tx_byte into that register.
REQ-017 The TX path SHALL be TX_CHECK, then TX_WRITE:
  - TX_CHECK reads addr 0.
  - If DAT_I[31] = 1 (FIFO full), return to IDLE and keep the byte held.
  - Otherwise go to TX_WRITE: write addr 0, data {24'b0, held byte}; on ACK clear the holding register and return to IDLE.
REQ-018 RX_READ SHALL read addr 1:
  - If DAT_I[31] = 0, load rx_byte = DAT_I[7:0] and set rx_valid = 1.
  - If DAT_I[31] = 1, return to IDLE with no change.
REQ-019 rx_valid SHALL clear in the cycle after rx_valid and rx_ready are both 1; no RX_READ is issued while rx_valid = 1, so no byte is lost.
REQ-020 The DIV computation SHALL be truncated to 16 bits; values of BAUD_RATE giving div < 0 are illegal parameterization.
REQ-021 ACK_I sampled while CYC_O = 0 SHALL be ignored.

Reset
REQ-022 When RST_I = 1, the block SHALL, at the next rising edge, return the FSM to INIT_DIV and clear the TX holding register.
REQ-023 At that reset edge, the block SHALL set the following output values:
  - CYC_O = STB_O = WR_O = 0.
  - ADR_O = 0, DAT_O = 0.
  - tx_ready = 0.
  - rx_valid = 0, rx_byte = 0.
  - init_done = 0.
  - bus_error = 0.
REQ-024 Reset asserted mid-transaction SHALL abort the transaction immediately (CYC_O = 0 at the next edge), and the initialization sequence SHALL restart.

Configuration
REQ-025 With macro UART_WB_MASTER_TIMEOUT_EN defined, the block SHALL count cycles from STB_O assertion.
REQ-026 With UART_WB_MASTER_TIMEOUT_EN defined, if ACK_I is not seen when the count reaches ACK_TIMEOUT, the block SHALL:
  - drop CYC_O and STB_O;
  - set bus_error = 1, sticky until reset;
  - return to IDLE, or restart INIT_DIV if the timeout occurred during init;
  - keep any held TX byte held.
REQ-027 Without UART_WB_MASTER_TIMEOUT_EN, the block SHALL wait for ACK_I indefinitely, and the bus_error port and timeout counter SHALL not exist.
REQ-028 bus_error SHALL be present only under UART_WB_MASTER_TIMEOUT_EN.

Verification
REQ-029 Reset, then a UART-model responder with ACK after 2 cycles -> writes addr6 = 85, addr2 = 32'h00000001, addr3 = 32'h00000001 in order; then init_done = 1.
REQ-030 tx_byte = 8'h41 with tx_valid, responder txdata full = 0 -> read addr0, then write addr0 data 32'h00000041; tx_ready returns to 1.
REQ-031 Responder reports full (bit31 = 1) three times, then 0 -> three TX_CHECK reads and exactly one write of the held byte; tx_ready = 0 throughout.
REQ-032 rxdata returns 32'h0000005A -> rx_valid = 1 and rx_byte = 8'h5A; with rx_ready = 0 held for 20 cycles, no addr1 read occurs until rx_ready pulses.
REQ-033 tx_valid and RX requests continuously pending -> addr0 and addr1 accesses alternate; at least one idle cycle exists between all transactions.
REQ-034 With UART_WB_MASTER_TIMEOUT_EN defined, ACK_I stuck at 0 -> CYC_O drops after 255 cycles and bus_error = 1; RST_I then clears bus_error.
